parametric_tensor_core_mma: RTL and testbench

Parametrised matrix-multiply-accumulate engine for the tensor core datapath. It computes R = A×B, or R = R + A×B in accumulate mode, for square N×N matrices of DATA_WIDTH elements. The block supports signed and unsigned operands and computes LANES result elements per cycle. It replaces the fixed 4×4, 4-bit, one-element-per-cycle core and sits between the tensor core register file and the result write-back path.

---
 rtl/tensor_core_pkg.sv | 20 ++
 rtl/tensor_core_dot_product.sv | 33 +++
 rtl/parametric_tensor_core_mma.sv | 116 +++++++++++
 tb/tb_parametric_tensor_core_mma.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tensor_core_pkg.sv
// tensor_core_pkg: shared FSM states, default accumulator width and element index helpers
// for the parametric tensor core MMA engine.
package tensor_core_pkg;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

    // Wide enough to hold N full-scale products summed without loss.
    function automatic int default_acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int row_of(input int e, input int n);
        return e / n;
    endfunction

    function automatic int col_of(input int e, input int n);
        return e % n;
    endfunction

endpackage

// File: rtl/tensor_core_dot_product.sv
// tensor_core_dot_product: combinational N-term dot product; operands are sign- or
// zero-extended to ACC_WIDTH so every product and the sum wrap modulo 2^ACC_WIDTH.
module tensor_core_dot_product
    import tensor_core_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = default_acc_width(DATA_WIDTH, N)
) (
    input  logic [N*DATA_WIDTH-1:0] a_row,
    input  logic [N*DATA_WIDTH-1:0] b_col,
    input  logic                    signed_mode,
    output logic [ACC_WIDTH-1:0]    sum
);

    localparam int EW = ACC_WIDTH - DATA_WIDTH;

    logic [N*ACC_WIDTH-1:0] prod;

    for (genvar k = 0; k < N; k++) begin : g_term
        logic [ACC_WIDTH-1:0] a_ext;
        logic [ACC_WIDTH-1:0] b_ext;
        assign a_ext = {{EW{signed_mode & a_row[k*DATA_WIDTH+DATA_WIDTH-1]}}, a_row[k*DATA_WIDTH +: DATA_WIDTH]};
        assign b_ext = {{EW{signed_mode & b_col[k*DATA_WIDTH+DATA_WIDTH-1]}}, b_col[k*DATA_WIDTH +: DATA_WIDTH]};
        assign prod[k*ACC_WIDTH +: ACC_WIDTH] = a_ext * b_ext;
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < N; k++) sum = sum + prod[k*ACC_WIDTH +: ACC_WIDTH];
    end

endmodule

// File: rtl/parametric_tensor_core_mma.sv
// parametric_tensor_core_mma: N x N matrix multiply(-accumulate), LANES result elements
// per cycle, operands latched at start and result held in a register between operations.
module parametric_tensor_core_mma
    import tensor_core_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = default_acc_width(DATA_WIDTH, N),
    parameter int LANES      = 1
) (
    input  logic                          clock_in,
    input  logic                          reset_in,
    input  logic                          start,
    input  logic                          accumulate_enable,
    input  logic                          signed_mode,
    input  logic [N*N*DATA_WIDTH-1:0]     matrix_a,
    input  logic [N*N*DATA_WIDTH-1:0]     matrix_b,
    output logic [N*N*ACC_WIDTH-1:0]      result,
    output logic                          busy,
    output logic                          done,
    output logic                          result_valid
);

    localparam int NN = N * N;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam int MW = NN * DATA_WIDTH;
    localparam int RW = N * DATA_WIDTH;

    state_e                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [MW-1:0]            a_q, a_d, b_q, b_d;
    logic                     acc_q, acc_d, sgn_q, sgn_d, valid_q, valid_d;
    logic [NN*ACC_WIDTH-1:0]  result_q, result_d;
    logic [LANES*ACC_WIDTH-1:0] lane_sum;
    logic                     last;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [RW-1:0] a_row;
        logic [RW-1:0] b_col;
        int            e;
        always_comb begin
            e     = int'(idx_q) + l;
            a_row = a_q[row_of(e, N)*RW +: RW];
            for (int k = 0; k < N; k++)
                b_col[k*DATA_WIDTH +: DATA_WIDTH] = b_q[(k*N + col_of(e, N))*DATA_WIDTH +: DATA_WIDTH];
        end
        tensor_core_dot_product #(
            .N(N), .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)
        ) u_dot (
            .a_row(a_row),
            .b_col(b_col),
            .signed_mode(sgn_q),
            .sum(lane_sum[l*ACC_WIDTH +: ACC_WIDTH])
        );
    end

    assign last = (idx_q == IW'(NN - LANES));

    // idx wraps to 0 on the final write so lane indices never leave the matrix.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        sgn_d    = sgn_q;
        valid_d  = valid_q;
        result_d = result_q;
        if (state_q == COMPUTE) begin
            for (int l = 0; l < LANES; l++)
                result_d[(int'(idx_q) + l)*ACC_WIDTH +: ACC_WIDTH] = lane_sum[l*ACC_WIDTH +: ACC_WIDTH]
                    + (acc_q ? result_q[(int'(idx_q) + l)*ACC_WIDTH +: ACC_WIDTH] : '0);
            idx_d   = last ? '0 : idx_q + IW'(LANES);
            state_d = last ? DONE : COMPUTE;
            valid_d = last;
        end else if (start) begin
            a_d     = matrix_a;
            b_d     = matrix_b;
            acc_d   = accumulate_enable;
            sgn_d   = signed_mode;
            idx_d   = '0;
            valid_d = 1'b0;
            state_d = COMPUTE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= 1'b0;
            sgn_q    <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            sgn_q    <= sgn_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign result       = result_q;
    assign busy         = (state_q == COMPUTE);
    assign done         = (state_q == DONE);
    assign result_valid = valid_q;

endmodule

// File: tb/tb_parametric_tensor_core_mma.sv
// tb_parametric_tensor_core_mma: directed checks of a LANES=1 and a LANES=4 instance
// driven from the same inputs.
module tb_parametric_tensor_core_mma;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int AW = 10;
    localparam int NN = N * N;

    logic clock_in = 1'b0;
    logic reset_in = 1'b1;
    logic start = 1'b0;
    logic accumulate_enable = 1'b0;
    logic signed_mode = 1'b0;
    logic [NN*DW-1:0] matrix_a = '0;
    logic [NN*DW-1:0] matrix_b = '0;
    logic [NN*AW-1:0] result1, result4;
    logic busy1, done1, valid1, busy4, done4, valid4;
    int tests = 0;
    int fails = 0;

    always #5 clock_in = ~clock_in;

    parametric_tensor_core_mma #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .LANES(1)) dut1 (
        .clock_in(clock_in), .reset_in(reset_in), .start(start),
        .accumulate_enable(accumulate_enable), .signed_mode(signed_mode),
        .matrix_a(matrix_a), .matrix_b(matrix_b), .result(result1),
        .busy(busy1), .done(done1), .result_valid(valid1)
    );

    parametric_tensor_core_mma #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .LANES(4)) dut4 (
        .clock_in(clock_in), .reset_in(reset_in), .start(start),
        .accumulate_enable(accumulate_enable), .signed_mode(signed_mode),
        .matrix_a(matrix_a), .matrix_b(matrix_b), .result(result4),
        .busy(busy4), .done(done4), .result_valid(valid4)
    );

    task automatic check(input string tag, input logic [NN*AW-1:0] obs, input logic [NN*AW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NN*AW-1:0] ramp(input int mul);
        logic [NN*AW-1:0] r;
        for (int e = 0; e < NN; e++) r[e*AW +: AW] = AW'(e * mul);
        return r;
    endfunction

    function automatic logic [NN*AW-1:0] splat_r(input int v);
        logic [NN*AW-1:0] r;
        for (int e = 0; e < NN; e++) r[e*AW +: AW] = AW'(v);
        return r;
    endfunction

    function automatic logic [NN*DW-1:0] splat_m(input int v);
        logic [NN*DW-1:0] m;
        for (int e = 0; e < NN; e++) m[e*DW +: DW] = DW'(v);
        return m;
    endfunction

    function automatic logic [NN*DW-1:0] ident();
        logic [NN*DW-1:0] m;
        for (int e = 0; e < NN; e++) m[e*DW +: DW] = (e / N == e % N) ? DW'(1) : DW'(0);
        return m;
    endfunction

    function automatic logic [NN*DW-1:0] ramp_m();
        logic [NN*DW-1:0] m;
        for (int e = 0; e < NN; e++) m[e*DW +: DW] = DW'(e);
        return m;
    endfunction

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic launch(input logic [NN*DW-1:0] a, input logic [NN*DW-1:0] b, input logic acc, input logic sgn);
        matrix_a = a;
        matrix_b = b;
        accumulate_enable = acc;
        signed_mode = sgn;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat1, output int lat4);
        lat1 = -1;
        lat4 = -1;
        for (int c = 1; c <= 40 && lat1 < 0; c++) begin
            step();
            if (done4 && lat4 < 0) lat4 = c;
            if (done1) lat1 = c;
        end
    endtask

    initial begin
        int lat1, lat4, pulses;
        repeat (3) step();
        check("reset_result1", result1, '0);
        check("reset_result4", result4, '0);
        check("reset_busy", {busy1, busy4}, '0);
        check("reset_done", {done1, done4}, '0);
        check("reset_valid", {valid1, valid4}, '0);
        reset_in = 1'b0;
        step();

        launch(ident(), ramp_m(), 1'b0, 1'b0);
        check("busy_after_start", {busy1, busy4}, 2'b11);
        wait_done(lat1, lat4);
        check("ident_latency_l1", lat1, 16);
        check("ident_latency_l4", lat4, 4);
        check("ident_result_l1", result1, ramp(1));
        check("ident_result_l4", result4, ramp(1));
        check("ident_valid", {valid1, valid4}, 2'b11);
        step();
        check("done_pulse_len", done1, 1'b0);
        check("idle_after_done", busy1, 1'b0);
        check("valid_held", valid1, 1'b1);

        launch(splat_m(15), splat_m(15), 1'b0, 1'b0);
        check("valid_cleared", {valid1, valid4}, 2'b00);
        wait_done(lat1, lat4);
        check("umax_result_l1", result1, splat_r(900));
        check("umax_result_l4", result4, splat_r(900));

        launch(splat_m(8), splat_m(8), 1'b0, 1'b1);
        wait_done(lat1, lat4);
        check("smin_sq_l1", result1, splat_r(256));
        check("smin_sq_l4", result4, splat_r(256));

        launch(splat_m(8), splat_m(7), 1'b0, 1'b1);
        wait_done(lat1, lat4);
        check("smin_max_l1", result1, splat_r('h320));
        check("smin_max_l4", result4, splat_r('h320));

        launch(ident(), ramp_m(), 1'b0, 1'b0);
        wait_done(lat1, lat4);
        check("acc_first_result", result1, ramp(1));
        launch(ident(), ramp_m(), 1'b1, 1'b0);
        wait_done(lat1, lat4);
        check("acc_done_gap", lat1 + 1, 17);
        check("acc_result_l1", result1, ramp(2));
        check("acc_result_l4", result4, ramp(2));

        step();
        launch(ident(), ramp_m(), 1'b0, 1'b0);
        repeat (4) step();
        #2;
        reset_in = 1'b1;
        #1;
        check("rst_mid_result1", result1, '0);
        check("rst_mid_result4", result4, '0);
        check("rst_mid_busy", busy1, 1'b0);
        check("rst_mid_done", done1, 1'b0);
        check("rst_mid_valid", valid1, 1'b0);
        step();
        reset_in = 1'b0;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (done1 || done4) pulses++;
        end
        check("rst_no_done", pulses, 0);

        launch(ident(), ramp_m(), 1'b0, 1'b0);
        step();
        matrix_a = splat_m(15);
        accumulate_enable = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (done4) pulses++;
            step();
        end
        check("l4_ignore_start_pulses", pulses, 1);
        check("l4_ignore_start_result", result4, ramp(1));
        check("l1_ignore_start_result", result1, ramp(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
